// File: rtl/phy_pkg.sv
// Shared definitions for the PHY transmit lane scheduler: FSM states, lane
// indices, default byte width and the target-lane selection rule.
package phy_pkg;

    localparam int DEF_DATA_W = 8;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_STALL    = 2'd2
    } state_t;

    // A single enabled lane pins the target; with both lanes on the pointer decides.
    function automatic logic pick_lane(input logic [1:0] lane_en, input logic ptr);
        logic lane;
        case (lane_en)
            2'b01:   lane = LANE0;
            2'b10:   lane = LANE1;
            default: lane = ptr;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/stripe_sched_if.sv
// Byte stream in, two striped lanes out, plus lane status. The scheduler
// takes the slave side; whatever drives the stream and lane sinks takes master.
interface stripe_sched_if
    import phy_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 8
);
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_out;
    logic [1:0]        lane_en;
    logic              full_lane0;
    logic              full_lane1;
    logic [DATA_W-1:0] data_lane0;
    logic [DATA_W-1:0] data_lane1;
    logic              valid_lane0;
    logic              valid_lane1;
    logic              lane_ptr;
    logic [CNT_W-1:0]  cnt_lane0;
    logic [CNT_W-1:0]  cnt_lane1;
    logic              stall;

    modport master (
        output valid_in, data_in, lane_en, full_lane0, full_lane1,
        input  ready_out, data_lane0, data_lane1, valid_lane0, valid_lane1,
               lane_ptr, cnt_lane0, cnt_lane1, stall
    );

    modport slave (
        input  valid_in, data_in, lane_en, full_lane0, full_lane1,
        output ready_out, data_lane0, data_lane1, valid_lane0, valid_lane1,
               lane_ptr, cnt_lane0, cnt_lane1, stall
    );
endinterface

// File: rtl/stripe_sched_lane_counter.sv
// Wrapping per-lane byte counter; advances by one on each enabled cycle.
module lane_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/stripe_sched.sv
// Alternates an incoming byte stream across two lanes with per-lane
// backpressure and enables; an idle gap realigns the next burst to lane 0.
module stripe_sched
    import phy_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IDLE_MAX = 4,
    parameter int CNT_W    = 8
) (
    input logic           clk_2f,
    input logic           reset_L,
    stripe_sched_if.slave bus
);
    localparam logic [3:0] IDLE_LIM = 4'(IDLE_MAX);

    state_t            state_q;
    logic              lane_ptr_q, lane_ptr_d;
    logic [3:0]        idle_q, idle_d;
    logic [DATA_W-1:0] data_q [2];
    logic [1:0]        valid_q;
    logic              stall_q;

    logic              tgt;
    logic              full_tgt;
    logic              lanes_on;
    logic              ready;
    logic              xfer;
    logic [1:0]        cnt_en;
    logic [CNT_W-1:0]  cnt_val [2];

    always_comb begin
        tgt      = pick_lane(bus.lane_en, lane_ptr_q);
        full_tgt = (tgt == LANE1) ? bus.full_lane1 : bus.full_lane0;
        lanes_on = |bus.lane_en;
        ready    = (state_q != ST_DISABLED) && lanes_on && !full_tgt;
        xfer     = bus.valid_in && ready;
    end

    // A transfer outranks the idle realign: it always moves the pointer and clears the gap count.
    always_comb begin
        lane_ptr_d = lane_ptr_q;
        idle_d     = idle_q;
        if (xfer) begin
            lane_ptr_d = (bus.lane_en == 2'b11) ? ~lane_ptr_q : tgt;
            idle_d     = '0;
        end else if (state_q == ST_RUN) begin
            if (idle_q != IDLE_LIM) begin
                idle_d = idle_q + 4'd1;
            end
            if (idle_d == IDLE_LIM) begin
                lane_ptr_d = LANE0;
            end
        end
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_DISABLED;
            lane_ptr_q <= LANE0;
            idle_q     <= '0;
            valid_q    <= '0;
            stall_q    <= 1'b0;
        end else begin
            lane_ptr_q <= lane_ptr_d;
            idle_q     <= idle_d;
            valid_q[0] <= xfer && (tgt == LANE0);
            valid_q[1] <= xfer && (tgt == LANE1);
            case (state_q)
                ST_DISABLED: begin
                    stall_q <= 1'b0;
                    if (lanes_on) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!lanes_on) begin
                        state_q <= ST_DISABLED;
                        stall_q <= 1'b0;
                    end else if (bus.valid_in && full_tgt) begin
                        state_q <= ST_STALL;
                        stall_q <= 1'b1;
                    end
                end
                ST_STALL: begin
                    // The pending byte stays upstream; nothing is dropped on disable.
                    if (!lanes_on) begin
                        state_q <= ST_DISABLED;
                        stall_q <= 1'b0;
                    end else if (!full_tgt) begin
                        state_q <= ST_RUN;
                        stall_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_DISABLED;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign cnt_en[gi] = xfer && (tgt == 1'(gi));

            always_ff @(posedge clk_2f or negedge reset_L) begin
                if (!reset_L) begin
                    data_q[gi] <= '0;
                end else if (cnt_en[gi]) begin
                    data_q[gi] <= bus.data_in;
                end
            end

            lane_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk    (clk_2f),
                .rst_n  (reset_L),
                .en_i   (cnt_en[gi]),
                .count_o(cnt_val[gi])
            );
        end
    endgenerate

    assign bus.ready_out   = ready;
    assign bus.data_lane0  = data_q[0];
    assign bus.data_lane1  = data_q[1];
    assign bus.valid_lane0 = valid_q[0];
    assign bus.valid_lane1 = valid_q[1];
    assign bus.lane_ptr    = lane_ptr_q;
    assign bus.cnt_lane0   = cnt_val[0];
    assign bus.cnt_lane1   = cnt_val[1];
    assign bus.stall       = stall_q;
endmodule

// File: tb/tb_stripe_sched.sv
// Bench for stripe_sched: directed scenarios plus a randomized run compared
// cycle by cycle against a behavioural model of the striping rules.
module tb_stripe_sched;
    localparam int IDLE_MAX = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stripe_sched_if #(.DATA_W(8), .CNT_W(8)) bus ();

    stripe_sched #(
        .DATA_W  (8),
        .IDLE_MAX(IDLE_MAX),
        .CNT_W   (8)
    ) dut (
        .clk_2f (clk),
        .reset_L(rst_n),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: enabled/stalled flags, lane pointer, idle gap length,
    // last byte, valid pulse and byte count per lane.
    bit         m_on, m_stall, m_ptr;
    int         m_idle;
    logic [7:0] m_data [2];
    bit         m_valid [2];
    logic [7:0] m_cnt [2];

    function automatic bit m_tgt();
        if (bus.lane_en == 2'b01) return 1'b0;
        if (bus.lane_en == 2'b10) return 1'b1;
        return m_ptr;
    endfunction

    function automatic bit m_ready();
        bit f;
        f = m_tgt() ? bus.full_lane1 : bus.full_lane0;
        return m_on && (bus.lane_en != 2'b00) && !f;
    endfunction

    task automatic model_reset();
        m_on = 0; m_stall = 0; m_ptr = 0; m_idle = 0;
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 8'h00; m_valid[i] = 0; m_cnt[i] = 8'h00;
        end
    endtask

    // Advance one clock with the current inputs; leaves time at posedge+1.
    task automatic tick();
        bit t, ft, rdy, x, v;
        bit [1:0] en;
        logic [7:0] d;
        en  = bus.lane_en;
        v   = bus.valid_in;
        d   = bus.data_in;
        t   = m_tgt();
        ft  = t ? bus.full_lane1 : bus.full_lane0;
        rdy = m_ready();
        x   = v && rdy;
        @(posedge clk);
        #1;
        m_valid[0] = x && !t;
        m_valid[1] = x && t;
        if (x) begin
            m_data[t] = d;
            m_cnt[t]  = m_cnt[t] + 8'd1;
            m_ptr     = (en == 2'b11) ? !m_ptr : t;
            m_idle    = 0;
        end else if (m_on && !m_stall) begin
            if (m_idle < IDLE_MAX) m_idle++;
            if (m_idle == IDLE_MAX) m_ptr = 0;
        end
        if (!m_on) begin
            m_on = (en != 2'b00);
        end else if (en == 2'b00) begin
            m_on = 0; m_stall = 0;
        end else if (!m_stall) begin
            m_stall = v && ft;
        end else begin
            m_stall = ft;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.valid_in = 0; bus.data_in = 8'h00; bus.lane_en = 2'b00;
        bus.full_lane0 = 0; bus.full_lane1 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.valid_in = 1; bus.data_in = 8'h99; bus.lane_en = 2'b11;
        bus.full_lane0 = 0; bus.full_lane1 = 0;
        model_reset();
        @(posedge clk); #1;
        checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready_out); end
        @(posedge clk); #1;
        checks++;
        if ({bus.valid_lane1, bus.valid_lane0, bus.lane_ptr, bus.stall} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {bus.valid_lane1, bus.valid_lane0, bus.lane_ptr, bus.stall});
        end
        checks++;
        if ({bus.cnt_lane1, bus.cnt_lane0, bus.data_lane1, bus.data_lane0} !== 32'h0) begin
            errors++; $display("FAIL reset_regs got=%h exp=0", {bus.cnt_lane1, bus.cnt_lane0, bus.data_lane1, bus.data_lane0});
        end
        bus.valid_in = 0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_alternate();
        logic [7:0] b;
        bit lane;
        bus.lane_en = 2'b11; bus.valid_in = 0;
        tick();
        for (int i = 0; i < 6; i++) begin
            b = 8'hA0 + 8'(i);
            lane = (i % 2) == 1;
            bus.valid_in = 1; bus.data_in = b;
            #1;
            checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL alt_ready byte=%h got=%b exp=1", b, bus.ready_out); end
            tick();
            checks++;
            if ({bus.valid_lane1, bus.valid_lane0, (lane ? bus.data_lane1 : bus.data_lane0)} !== {lane, !lane, b}) begin
                errors++; $display("FAIL alt_out byte=%h got v1=%b v0=%b d=%h exp lane%0d", b, bus.valid_lane1, bus.valid_lane0,
                                   lane ? bus.data_lane1 : bus.data_lane0, lane);
            end
        end
        bus.valid_in = 0;
        checks++;
        if ({bus.cnt_lane0, bus.cnt_lane1} !== {8'd3, 8'd3}) begin
            errors++; $display("FAIL alt_cnt got=%0d/%0d exp=3/3", bus.cnt_lane0, bus.cnt_lane1);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] tb_data [7] = '{8'h10, 8'h11, 8'h11, 8'h11, 8'h11, 8'h12, 8'h13};
        bit         tb_full [7] = '{0, 1, 1, 1, 0, 0, 0};
        bit         tb_rdy  [7] = '{1, 0, 0, 0, 1, 1, 1};
        bit         tb_stl  [7] = '{0, 1, 1, 1, 0, 0, 0};
        logic [1:0] tb_v    [7] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
        logic [7:0] got_d;
        bus.lane_en = 2'b11;
        for (int k = 0; k < 7; k++) begin
            bus.valid_in = 1; bus.data_in = tb_data[k]; bus.full_lane1 = tb_full[k];
            #1;
            checks++; if (bus.ready_out !== tb_rdy[k]) begin errors++; $display("FAIL bp_ready step=%0d got=%b exp=%b", k, bus.ready_out, tb_rdy[k]); end
            tick();
            checks++; if (bus.stall !== tb_stl[k]) begin errors++; $display("FAIL bp_stall step=%0d got=%b exp=%b", k, bus.stall, tb_stl[k]); end
            got_d = tb_v[k][1] ? bus.data_lane1 : bus.data_lane0;
            checks++;
            if ({bus.valid_lane1, bus.valid_lane0} !== tb_v[k] || (tb_v[k] != 2'b00 && got_d !== tb_data[k])) begin
                errors++; $display("FAIL bp_out step=%0d got v=%b%b d=%h exp v=%b d=%h", k, bus.valid_lane1, bus.valid_lane0, got_d, tb_v[k], tb_data[k]);
            end
        end
        bus.valid_in = 0; bus.full_lane1 = 0;
        checks++;
        if ({bus.cnt_lane0, bus.cnt_lane1} !== {8'd5, 8'd5}) begin
            errors++; $display("FAIL bp_cnt got=%0d/%0d exp=5/5", bus.cnt_lane0, bus.cnt_lane1);
        end
    endtask

    task automatic test_idle_realign();
        int gap;
        bit lane;
        bus.lane_en = 2'b11;
        for (int rep = 0; rep < 2; rep++) begin
            gap  = (rep == 0) ? IDLE_MAX : IDLE_MAX - 1;
            lane = (rep == 1);
            bus.valid_in = 0;
            repeat (IDLE_MAX) tick();
            checks++; if (bus.lane_ptr !== 1'b0) begin errors++; $display("FAIL idle_pre_ptr rep=%0d got=%b exp=0", rep, bus.lane_ptr); end
            bus.valid_in = 1; bus.data_in = 8'h30 + 8'(rep);
            tick();
            bus.valid_in = 0;
            repeat (gap) tick();
            checks++; if (bus.lane_ptr !== lane) begin errors++; $display("FAIL idle_ptr gap=%0d got=%b exp=%b", gap, bus.lane_ptr, lane); end
            bus.valid_in = 1; bus.data_in = 8'h55;
            tick();
            bus.valid_in = 0;
            checks++;
            if ({bus.valid_lane1, bus.valid_lane0, (lane ? bus.data_lane1 : bus.data_lane0)} !== {lane, !lane, 8'h55}) begin
                errors++; $display("FAIL idle_out gap=%0d got v1=%b v0=%b exp lane%0d", gap, bus.valid_lane1, bus.valid_lane0, lane);
            end
        end
    endtask

    task automatic test_single_lane();
        logic [7:0] b;
        bus.lane_en = 2'b10;
        for (int i = 1; i <= 3; i++) begin
            b = 8'(i);
            bus.valid_in = 1; bus.data_in = b;
            #1;
            checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL single_ready byte=%h got=%b exp=1", b, bus.ready_out); end
            tick();
            checks++;
            if ({bus.valid_lane1, bus.valid_lane0, bus.data_lane1} !== {2'b10, b}) begin
                errors++; $display("FAIL single_out byte=%h got v1=%b v0=%b d1=%h exp v1=1 v0=0 d1=%h", b, bus.valid_lane1, bus.valid_lane0, bus.data_lane1, b);
            end
        end
        bus.data_in = 8'h04; bus.lane_en = 2'b00;
        #1;
        checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL off_ready got=%b exp=0", bus.ready_out); end
        tick();
        bus.lane_en = 2'b11;
        #1;
        checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL disabled_ready got=%b exp=0", bus.ready_out); end
        tick();
        checks++; if ({bus.valid_lane1, bus.valid_lane0} !== 2'b00) begin errors++; $display("FAIL disabled_valid got=%b%b exp=00", bus.valid_lane1, bus.valid_lane0); end
        #1;
        checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL reenable_ready got=%b exp=1", bus.ready_out); end
        tick();
        bus.valid_in = 0;
        checks++;
        if ({bus.valid_lane1, bus.data_lane1} !== {1'b1, 8'h04}) begin
            errors++; $display("FAIL reenable_out got v1=%b d1=%h exp v1=1 d1=04", bus.valid_lane1, bus.data_lane1);
        end
    endtask

    task automatic test_async_reset();
        bus.lane_en = 2'b11;
        for (int i = 0; i < 3; i++) begin
            bus.valid_in = 1; bus.data_in = 8'hC0 + 8'(i);
            tick();
        end
        bus.data_in = 8'hC3;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.valid_lane1, bus.valid_lane0, bus.lane_ptr, bus.stall, bus.ready_out} !== 5'b0) begin
            errors++; $display("FAIL arst_flags got v=%b%b ptr=%b stall=%b rdy=%b exp all 0", bus.valid_lane1, bus.valid_lane0, bus.lane_ptr, bus.stall, bus.ready_out);
        end
        checks++;
        if ({bus.cnt_lane0, bus.cnt_lane1} !== 16'h0) begin
            errors++; $display("FAIL arst_cnt got=%0d/%0d exp=0/0", bus.cnt_lane0, bus.cnt_lane1);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL arst_ready got=%b exp=0", bus.ready_out); end
        tick();
        checks++; if ({bus.valid_lane1, bus.valid_lane0} !== 2'b00) begin errors++; $display("FAIL arst_ghost got=%b%b exp=00", bus.valid_lane1, bus.valid_lane0); end
        bus.data_in = 8'h77;
        tick();
        bus.valid_in = 0;
        checks++;
        if ({bus.valid_lane1, bus.valid_lane0, bus.data_lane0} !== {2'b01, 8'h77}) begin
            errors++; $display("FAIL arst_first got v1=%b v0=%b d0=%h exp v0=1 d0=77", bus.valid_lane1, bus.valid_lane0, bus.data_lane0);
        end
    endtask

    task automatic test_wrap();
        int bad_rdy = 0, bad_stall = 0;
        do_reset();
        bus.lane_en = 2'b11;
        tick();
        for (int i = 0; i < 512; i++) begin
            bus.valid_in = 1; bus.data_in = 8'(i);
            #1;
            if (bus.ready_out !== 1'b1) bad_rdy++;
            tick();
            if (bus.stall !== 1'b0) bad_stall++;
            if (i == 255) begin
                checks++;
                if ({bus.cnt_lane0, bus.cnt_lane1} !== {8'd128, 8'd128}) begin
                    errors++; $display("FAIL wrap_mid got=%0d/%0d exp=128/128", bus.cnt_lane0, bus.cnt_lane1);
                end
            end
        end
        bus.valid_in = 0;
        checks++; if (bad_rdy != 0) begin errors++; $display("FAIL wrap_ready not-ready cycles got=%0d exp=0", bad_rdy); end
        checks++; if (bad_stall != 0) begin errors++; $display("FAIL wrap_stall stall cycles got=%0d exp=0", bad_stall); end
        checks++;
        if ({bus.cnt_lane0, bus.cnt_lane1} !== 16'h0) begin
            errors++; $display("FAIL wrap_cnt got=%0d/%0d exp=0/0", bus.cnt_lane0, bus.cnt_lane1);
        end
    endtask

    task automatic test_random();
        logic [35:0] got, exp;
        bit busy;
        do_reset();
        bus.lane_en = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            busy = ((c / 150) % 2) == 0;
            if ($urandom_range(15) == 0) bus.lane_en = 2'($urandom_range(3));
            else if (bus.lane_en == 2'b00 && $urandom_range(3) == 0) bus.lane_en = 2'b11;
            bus.valid_in   = busy ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            bus.data_in    = 8'($urandom);
            bus.full_lane0 = ($urandom_range(5) == 0);
            bus.full_lane1 = ($urandom_range(5) == 0);
            #1;
            checks++;
            if (bus.ready_out !== m_ready()) begin
                errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.ready_out, m_ready());
            end
            tick();
            got = {bus.valid_lane1, bus.valid_lane0, bus.data_lane1, bus.data_lane0,
                   bus.cnt_lane1, bus.cnt_lane0, bus.lane_ptr, bus.stall};
            exp = {m_valid[1], m_valid[0], m_data[1], m_data[0], m_cnt[1], m_cnt[0], m_ptr, m_stall};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL rand_state cyc=%0d got=%h exp=%h (v1 v0 d1 d0 c1 c0 ptr stall)", c, got, exp);
            end
        end
        bus.valid_in = 0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_backpressure();
        test_idle_realign();
        test_single_lane();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
